tlb_port_arbiter: RTL and testbench

// - Shares the single TLB lookup/maintenance port among three requesters: instruction fetch (IF),

---
 rtl/tlb_arb_pkg.sv | 30 +++
 rtl/tlb_arb_pick.sv | 60 ++++++
 rtl/tlb_port_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_tlb_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tlb_arb_pkg.sv
// Shared types and constants for the TLB port arbiter (tlb_port_arbiter, tlb_arb_pick).
package tlb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IF,
    SRC_DM,
    SRC_MT
  } src_e;

  // Bit positions inside the one-hot mt_op {TLBR,TLBP,TLBWI,TLBWR}
  localparam int unsigned OP_TLBR  = 3;
  localparam int unsigned OP_TLBP  = 2;
  localparam int unsigned OP_TLBWI = 1;
  localparam int unsigned OP_TLBWR = 0;

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned TMO_W    = 8;

  function automatic logic is_xlate(input src_e s);
    return (s == SRC_IF) || (s == SRC_DM);
  endfunction

endpackage

// File: rtl/tlb_arb_pick.sv
// Winner select for the TLB port (MT > DM > IF with an IF anti-starvation override)
// plus the registered DM streak counter that drives the override.
module tlb_arb_pick
  import tlb_arb_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic mt_req_i,
  input  logic cancel_i,
  output src_e grant_o
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                if_ok, dm_ok, force_if;

  // A flush blocks new translations but never a CP0 TLB instruction.
  assign if_ok    = if_req_i && !cancel_i;
  assign dm_ok    = dm_req_i && !cancel_i;
  assign force_if = (streak_q == STREAK_MAX) && if_req_i;

  always_comb begin
    grant_o = SRC_NONE;
    if (arb_en_i) begin
      if (force_if && if_ok) begin
        grant_o = SRC_IF;
      end else if (mt_req_i) begin
        grant_o = SRC_MT;
      end else if (dm_ok) begin
        grant_o = SRC_DM;
      end else if (if_ok) begin
        grant_o = SRC_IF;
      end
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (!if_req_i || (grant_o == SRC_IF)) begin
      streak_d = '0;
    end else if ((grant_o == SRC_DM) && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Shares the single TLB port between IF, DM and CP0 (MT); one transaction outstanding.
// Optional performance counters are built when TLB_ARB_PERF_CNT_EN is defined.
module tlb_port_arbiter
  import tlb_arb_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned RESP_TIMEOUT  = 63
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cancel,
  input  logic        if_req,
  input  logic [31:0] if_vaddr,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [31:0] dm_vaddr,
  input  logic        dm_store,
  output logic        dm_ack,
  input  logic        mt_req,
  input  logic [3:0]  mt_op,
  output logic        mt_ack,
  output logic        if_done,
  output logic        dm_done,
  output logic        mt_done,
  output logic        err,
  output logic        tlb_valid,
  input  logic        tlb_ready,
  output logic [31:0] tlb_vaddr,
  output logic        tlb_store,
  output logic [3:0]  tlb_op,
  input  logic        tlb_resp
`ifdef TLB_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_conflict,
  output logic [15:0] perf_timeout
`endif
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

  state_e             state_q, state_d;
  src_e               src_q, src_d;
  src_e               grant;
  logic [31:0]        vaddr_q, vaddr_d;
  logic               store_q, store_d;
  logic [3:0]         op_q, op_d;
  logic               kill_q, kill_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               arb_en, xlate, kill_now, tmo_fire, done_any;

  assign arb_en   = (state_q == IDLE);
  assign xlate    = is_xlate(src_q);
  assign kill_now = kill_q || (cancel && xlate);
  assign tmo_fire = (state_q == WAIT) && !tlb_resp && (tmo_q == TMO_LAST);

  tlb_arb_pick #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_pick (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .arb_en_i(arb_en),
    .if_req_i(if_req),
    .dm_req_i(dm_req),
    .mt_req_i(mt_req),
    .cancel_i(cancel),
    .grant_o (grant)
  );

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    vaddr_d  = vaddr_q;
    store_d  = store_q;
    op_d     = op_q;
    kill_d   = kill_q;
    tmo_d    = tmo_q;
    if_ack   = 1'b0;
    dm_ack   = 1'b0;
    mt_ack   = 1'b0;
    done_any = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant != SRC_NONE) begin
          src_d   = grant;
          kill_d  = 1'b0;
          state_d = ISSUE;
          vaddr_d = '0;
          store_d = 1'b0;
          op_d    = '0;
          case (grant)
            SRC_IF: begin
              if_ack  = 1'b1;
              vaddr_d = if_vaddr;
            end
            SRC_DM: begin
              dm_ack  = 1'b1;
              vaddr_d = dm_vaddr;
              store_d = dm_store;
            end
            SRC_MT: begin
              mt_ack         = 1'b1;
              op_d[OP_TLBR]  = mt_op[OP_TLBR];
              op_d[OP_TLBP]  = mt_op[OP_TLBP];
              op_d[OP_TLBWI] = mt_op[OP_TLBWI];
              op_d[OP_TLBWR] = mt_op[OP_TLBWR];
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        // Once the TLB has taken the request it must be drained, so a flush
        // then only marks the transaction as killed.
        if (tlb_ready) begin
          state_d = WAIT;
          tmo_d   = '0;
          kill_d  = cancel && xlate;
        end else if (cancel && xlate) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (tlb_resp) begin
          state_d  = IDLE;
          done_any = !kill_now;
        end else if (tmo_fire) begin
          state_d  = IDLE;
          done_any = !kill_now;
          err      = !kill_now;
        end else begin
          tmo_d  = tmo_q + TMO_W'(1);
          kill_d = kill_now;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_done   = done_any && (src_q == SRC_IF);
  assign dm_done   = done_any && (src_q == SRC_DM);
  assign mt_done   = done_any && (src_q == SRC_MT);
  assign tlb_valid = (state_q == ISSUE);
  assign tlb_vaddr = tlb_valid ? vaddr_q : '0;
  assign tlb_store = tlb_valid && store_q;
  assign tlb_op    = tlb_valid ? op_q : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      src_q   <= SRC_NONE;
      vaddr_q <= '0;
      store_q <= 1'b0;
      op_q    <= '0;
      kill_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      vaddr_q <= vaddr_d;
      store_q <= store_d;
      op_q    <= op_d;
      kill_q  <= kill_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef TLB_ARB_PERF_CNT_EN
  logic [31:0] conflict_q;
  logic [15:0] timeout_q;
  logic        conflict;

  assign conflict = arb_en && ((if_req && dm_req) || (if_req && mt_req) || (dm_req && mt_req));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_q <= '0;
      timeout_q  <= '0;
    end else begin
      if (conflict) conflict_q <= conflict_q + 32'd1;
      if (tmo_fire) timeout_q  <= timeout_q + 16'd1;
    end
  end

  assign perf_conflict = conflict_q;
  assign perf_timeout  = timeout_q;
`endif

endmodule

// File: tb/tb_tlb_port_arbiter.sv
// Directed bench for tlb_port_arbiter: cycle-by-cycle vector table plus timeout and reset sequences.
module tb_tlb_port_arbiter;

  localparam logic [31:0] IF_VA = 32'h0040_0000;
  localparam logic [31:0] DM_VA = 32'h8000_1234;
  localparam logic [1:0]  PN = 2'd0, PIF = 2'd1, PDM = 2'd2;

  logic        clk = 1'b0;
  logic        resetn, cancel;
  logic        if_req, dm_req, mt_req, dm_store;
  logic [31:0] if_vaddr, dm_vaddr;
  logic [3:0]  mt_op;
  logic        if_ack, dm_ack, mt_ack, if_done, dm_done, mt_done, err;
  logic        tlb_valid, tlb_ready, tlb_store, tlb_resp;
  logic [31:0] tlb_vaddr;
  logic [3:0]  tlb_op;
`ifdef TLB_ARB_PERF_CNT_EN
  logic [31:0] perf_conflict;
  logic [15:0] perf_timeout;
`endif

  always #5 clk = ~clk;

  assign if_vaddr = IF_VA;
  assign dm_vaddr = DM_VA;
  assign dm_store = 1'b1;

  tlb_port_arbiter #(
    .MAX_DM_STREAK(4),
    .RESP_TIMEOUT (63)
  ) dut (
    .clk(clk), .resetn(resetn), .cancel(cancel),
    .if_req(if_req), .if_vaddr(if_vaddr), .if_ack(if_ack),
    .dm_req(dm_req), .dm_vaddr(dm_vaddr), .dm_store(dm_store), .dm_ack(dm_ack),
    .mt_req(mt_req), .mt_op(mt_op), .mt_ack(mt_ack),
    .if_done(if_done), .dm_done(dm_done), .mt_done(mt_done), .err(err),
    .tlb_valid(tlb_valid), .tlb_ready(tlb_ready), .tlb_vaddr(tlb_vaddr),
    .tlb_store(tlb_store), .tlb_op(tlb_op), .tlb_resp(tlb_resp)
`ifdef TLB_ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_timeout(perf_timeout)
`endif
  );

  // req/ack/done are {mt,dm,if}; pay selects the expected forwarded vaddr/store
  typedef struct {
    logic [2:0] req;
    logic       cancel, ready, resp;
    logic [3:0] op;
    logic [2:0] ack, done;
    logic       err, valid;
    logic [1:0] pay;
    logic [3:0] top;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] req, input logic cn, input logic rdy, input logic rsp,
                              input logic [3:0] op, input logic [2:0] ack, input logic [2:0] done,
                              input logic e, input logic vld, input logic [1:0] pay, input logic [3:0] top);
    vec_t v;
    v.req = req; v.cancel = cn; v.ready = rdy; v.resp = rsp; v.op = op;
    v.ack = ack; v.done = done; v.err = e; v.valid = vld; v.pay = pay; v.top = top;
    return v;
  endfunction

  function automatic logic [63:0] exp_bits(input vec_t v);
    logic [31:0] va;
    logic        st;
    va = 32'h0;
    st = 1'b0;
    if (v.pay == PIF) va = IF_VA;
    if (v.pay == PDM) begin
      va = DM_VA;
      st = 1'b1;
    end
    return 64'({v.ack, v.done, v.err, v.valid, st, v.top, va});
  endfunction

  function automatic logic [63:0] act_bits();
    return 64'({mt_ack, dm_ack, if_ack, mt_done, dm_done, if_done, err, tlb_valid, tlb_store, tlb_op, tlb_vaddr});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(posedge clk);
    #1;
    {mt_req, dm_req, if_req} = v.req;
    cancel    = v.cancel;
    tlb_ready = v.ready;
    tlb_resp  = v.resp;
    mt_op     = v.op;
    @(negedge clk);
    chk(name, act_bits(), exp_bits(v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] gs [6];
    gs = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};

    resetn = 1'b0; cancel = 1'b0; if_req = 1'b0; dm_req = 1'b0; mt_req = 1'b0;
    mt_op = 4'h0; tlb_ready = 1'b0; tlb_resp = 1'b0;

    // Single IF transaction: ack, issue, one idle WAIT, response
    tbl.push_back(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b001,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    // All three at once: MT (TLBWI), then DM, then IF
    tbl.push_back(mk(3'b111,0,1,0,4'b0010, 3'b100,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b011,0,1,0,4'h0, 3'b000,3'b000,0,1,PN,4'b0010));
    tbl.push_back(mk(3'b011,0,1,1,4'h0, 3'b000,3'b100,0,0,PN,4'h0));
    tbl.push_back(mk(3'b011,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b001,0,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0));
    tbl.push_back(mk(3'b001,0,1,1,4'h0, 3'b000,3'b010,0,0,PN,4'h0));
    tbl.push_back(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b001,0,0,PN,4'h0));
    // DM and IF held: DM,DM,DM,DM,IF,DM (resp held high, ignored outside WAIT)
    foreach (gs[k]) begin
      tbl.push_back(mk(3'b011,0,1,1,4'h0, gs[k],3'b000,0,0,PN,4'h0));
      tbl.push_back(mk(3'b011,0,1,1,4'h0, 3'b000,3'b000,0,1,(gs[k] == 3'b001) ? PIF : PDM,4'h0));
      tbl.push_back(mk(3'b011,0,1,1,4'h0, 3'b000,gs[k],0,0,PN,4'h0));
    end
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    // DM cancelled in WAIT, response next cycle suppressed, next DM normal
    tbl.push_back(mk(3'b010,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0));
    tbl.push_back(mk(3'b000,1,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b010,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b010,0,0,PN,4'h0));
    // IF: cancel and resp in the same WAIT cycle -> no done
    tbl.push_back(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0));
    tbl.push_back(mk(3'b000,1,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    // cancel in IDLE blocks IF but not MT; MT ignores cancel; IF dropped in ISSUE with ready=0
    tbl.push_back(mk(3'b001,1,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b101,1,1,0,4'b1000, 3'b100,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b001,1,1,0,4'h0, 3'b000,3'b000,0,1,PN,4'b1000));
    tbl.push_back(mk(3'b001,1,1,1,4'h0, 3'b000,3'b100,0,0,PN,4'h0));
    tbl.push_back(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,1,0,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    // DM cancelled in ISSUE while TLB accepts -> drained, no done
    tbl.push_back(mk(3'b010,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,1,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0));
    tbl.push_back(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0));
    tbl.push_back(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", act_bits(), 64'h0);
    resetn = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

    // Timeout: MT TLBP with no response; done+err on the 63rd WAIT cycle
    apply(mk(3'b100,0,1,0,4'b0100, 3'b100,3'b000,0,0,PN,4'h0), "tmo_ack");
    apply(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PN,4'b0100), "tmo_issue");
    for (int i = 0; i < 62; i++)
      apply(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0), $sformatf("tmo_wait%0d", i));
    apply(mk(3'b000,0,1,0,4'h0, 3'b000,3'b100,1,0,PN,4'h0), "tmo_fire");
    apply(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0), "tmo_late_resp");
    apply(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0), "tmo_next_ack");
    apply(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0), "tmo_next_issue");
    apply(mk(3'b000,0,1,1,4'h0, 3'b000,3'b001,0,0,PN,4'h0), "tmo_next_done");

    // Build streak to 4, then reset mid-WAIT of the 4th DM
    for (int k = 0; k < 3; k++) begin
      apply(mk(3'b011,0,1,1,4'h0, 3'b010,3'b000,0,0,PN,4'h0), "rst_pre_ack");
      apply(mk(3'b011,0,1,1,4'h0, 3'b000,3'b000,0,1,PDM,4'h0), "rst_pre_issue");
      apply(mk(3'b011,0,1,1,4'h0, 3'b000,3'b010,0,0,PN,4'h0), "rst_pre_done");
    end
    apply(mk(3'b011,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0), "rst_dm4_ack");
    apply(mk(3'b011,0,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0), "rst_dm4_issue");
    apply(mk(3'b011,0,1,0,4'h0, 3'b000,3'b000,0,0,PN,4'h0), "rst_dm4_wait");
    @(posedge clk);
    #1;
    if_req = 1'b0; dm_req = 1'b0; tlb_resp = 1'b1;
    #2 resetn = 1'b0;
    #1 chk("rst_async_outputs", act_bits(), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_outputs", act_bits(), 64'h0);
    resetn = 1'b1;
    apply(mk(3'b000,0,1,1,4'h0, 3'b000,3'b000,0,0,PN,4'h0), "rst_no_stray_done");
    apply(mk(3'b011,0,1,0,4'h0, 3'b010,3'b000,0,0,PN,4'h0), "rst_streak_cleared");
    apply(mk(3'b001,0,1,0,4'h0, 3'b000,3'b000,0,1,PDM,4'h0), "rst_post_issue");
    apply(mk(3'b001,0,1,1,4'h0, 3'b000,3'b010,0,0,PN,4'h0), "rst_post_done");
    apply(mk(3'b001,0,1,0,4'h0, 3'b001,3'b000,0,0,PN,4'h0), "rst_post_if_ack");
    apply(mk(3'b000,0,1,0,4'h0, 3'b000,3'b000,0,1,PIF,4'h0), "rst_post_if_issue");
    apply(mk(3'b000,0,1,1,4'h0, 3'b000,3'b001,0,0,PN,4'h0), "rst_post_if_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
